seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display, parametrised

---
 rtl/seg7_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display.
//   It holds a double-buffered copy of a packed BCD/hex word and scans one
//   digit per slot. Each slot starts with a short all-dark gap so the previous
//   digit's segments do not ghost onto the next anode. All outputs are
//   registered and active-low.
//
//   Build option: define SEG7_LZB_EN to add leading-zero blanking. A digit
//   k > 0 whose code is 0 shows no segments when every higher digit is also 0.
//   Its DP is still driven. Without the macro, no blanking logic is built.
//
// Parameters
//   NUM_DIGITS    digits scanned (1..8)
//   CLK_DIV       clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  dark cycles at the start of each slot (0..CLK_DIV-1)
//   HEX_MODE      1: codes 10-15 show A b C d E F; 0: codes 10-15 are blank
//
// Ports
//   iClk     in   system clock, rising edge
//   iRst_n   in   asynchronous active-low reset
//   iData    in   packed 4-bit codes, digit 0 = iData[3:0] (rightmost)
//   iDp      in   decimal-point request per digit, 1 = lit
//   iLoad    in   one-cycle strobe that captures iData/iDp
//   oAn      out  anode select, active-low, at most one low
//   oSeg     out  segments {g,f,e,d,c,b,a}, active-low
//   oDp      out  decimal point, active-low
//   oFrame   out  one-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_MODE     = 0
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [4*NUM_DIGITS-1:0] iData,
  input  logic [NUM_DIGITS-1:0]   iDp,
  input  logic                    iLoad,
  output logic [NUM_DIGITS-1:0]   oAn,
  output logic [6:0]              oSeg,
  output logic                    oDp,
  output logic                    oFrame
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        r_prescale;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pendData;
  logic [NUM_DIGITS-1:0]   r_pendDp;
  logic                    r_pendValid;
  logic [4*NUM_DIGITS-1:0] r_actData;
  logic [NUM_DIGITS-1:0]   r_actDp;

  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_actDataNext;
  logic [NUM_DIGITS-1:0]   w_actDpNext;
  logic [3:0]              w_code;
  logic [6:0]              w_segDigit;
  logic                    w_inBlank;
  logic [NUM_DIGITS-1:0]   w_anSel;

  // Active-low gfedcba patterns. Codes 10-15 decode only in hex mode.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = 7'h7F;
    case (code)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = (HEX_MODE != 0) ? 7'b0001000 : 7'h7F;
      4'hB: seg = (HEX_MODE != 0) ? 7'b0000011 : 7'h7F;
      4'hC: seg = (HEX_MODE != 0) ? 7'b1000110 : 7'h7F;
      4'hD: seg = (HEX_MODE != 0) ? 7'b0100001 : 7'h7F;
      4'hE: seg = (HEX_MODE != 0) ? 7'b0000110 : 7'h7F;
      4'hF: seg = (HEX_MODE != 0) ? 7'b0001110 : 7'h7F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Slot prescaler and digit index. The index advances once per slot.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_prescale <= '0;
      r_idx      <= '0;
    end else if (r_prescale == PRE_LAST) begin
      r_prescale <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  assign w_wrap = (r_prescale == PRE_LAST) && (r_idx == IDX_LAST);

  // The frame boundary is the cycle oFrame is high, which is the first
  // cycle of the digit-0 slot. Decoding in that cycle already uses the
  // next active value, so a load there or a pending load is shown for the
  // whole new frame and no frame is ever torn.
  always_comb begin
    w_actDataNext = r_actData;
    w_actDpNext   = r_actDp;
    if (oFrame) begin
      if (iLoad) begin
        w_actDataNext = iData;
        w_actDpNext   = iDp;
      end else if (r_pendValid) begin
        w_actDataNext = r_pendData;
        w_actDpNext   = r_pendDp;
      end
    end
  end

  // Pending and active buffers. When several loads arrive in one frame,
  // the last load wins.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pendData  <= '0;
      r_pendDp    <= '0;
      r_pendValid <= 1'b0;
      r_actData   <= '0;
      r_actDp     <= '0;
    end else begin
      r_actData <= w_actDataNext;
      r_actDp   <= w_actDpNext;
      if (oFrame) begin
        r_pendValid <= 1'b0;
      end else if (iLoad) begin
        r_pendData  <= iData;
        r_pendDp    <= iDp;
        r_pendValid <= 1'b1;
      end
    end
  end

  assign w_code    = w_actDataNext[{r_idx, 2'b00} +: 4];
  assign w_inBlank = (int'(r_prescale) < BLANK_CYCLES);
  assign w_anSel   = ~(NUM_DIGITS'(1) << r_idx);

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] w_lzBlank;

  // Walk down from the most significant digit. A digit is blanked while
  // every code seen so far (itself included) is zero. Digit 0 is never blanked.
  always_comb begin
    logic zeroRun;
    zeroRun   = 1'b1;
    w_lzBlank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zeroRun      = zeroRun & (w_actDataNext[4*k +: 4] == 4'h0);
      w_lzBlank[k] = zeroRun;
    end
  end

  assign w_segDigit = w_lzBlank[r_idx] ? 7'h7F : f_decode(w_code);
`else
  assign w_segDigit = f_decode(w_code);
`endif

  // Registered outputs. They lag the prescaler and index by one cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAn    <= '1;
      oSeg   <= 7'h7F;
      oDp    <= 1'b1;
      oFrame <= 1'b0;
    end else begin
      oFrame <= w_wrap;
      if (w_inBlank) begin
        oAn  <= '1;
        oSeg <= 7'h7F;
        oDp  <= 1'b1;
      end else begin
        oAn  <= w_anSel;
        oSeg <= w_segDigit;
        oDp  <= ~w_actDpNext[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int P  = ND * CD;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [15:0] iData;
  logic [3:0]  iDp;
  logic        iLoad;
  logic [3:0]  anDec, anHex;
  logic [6:0]  segDec, segHex;
  logic        dpDec, dpHex, frameDec, frameHex;

  int nVectors = 0;
  int nMiscompares = 0;
  int s = 0;
  logic [15:0] mActData, mLatData;
  logic [3:0]  mActDp, mLatDp;
  logic [6:0]  decTab [10];
  logic [6:0]  hexTab [6];

  always #5 iClk = ~iClk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_MODE(0)) dutDec (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iDp(iDp), .iLoad(iLoad),
    .oAn(anDec), .oSeg(segDec), .oDp(dpDec), .oFrame(frameDec)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_MODE(1)) dutHex (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iDp(iDp), .iLoad(iLoad),
    .oAn(anHex), .oSeg(segHex), .oDp(dpHex), .oFrame(frameHex)
  );

  // Count one comparison and report it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s (state %0d): got %h, expected %h", tag, s, observed, expected);
    end
  endtask

  // Compute the expected segments for a digit from the displayed word.
  function automatic logic [6:0] expSeg(input logic [15:0] word, input int idx, input bit hex);
    logic [3:0] code;
    code = 4'((word >> (4 * idx)) & 16'hF);
`ifdef SEG7_LZB_EN
    if (idx > 0 && (word >> (4 * idx)) == 16'h0) return 7'h7F;
`endif
    if (code < 10) return decTab[code];
    if (hex) return hexTab[code - 10];
    return 7'h7F;
  endfunction

  task automatic checkDark(input string tag);
    checkOutput({tag, ".anDec"}, 16'(anDec), 16'hF);
    checkOutput({tag, ".segDec"}, 16'(segDec), 16'h7F);
    checkOutput({tag, ".dpDec"}, 16'(dpDec), 16'h1);
    checkOutput({tag, ".frameDec"}, 16'(frameDec), 16'h0);
    checkOutput({tag, ".anHex"}, 16'(anHex), 16'hF);
    checkOutput({tag, ".segHex"}, 16'(segHex), 16'h7F);
  endtask

  // Drive one cycle of input, update the frame-level model, step the clock,
  // then check the outputs against the scan position that was just left.
  task automatic applyStimulus(input bit load, input logic [15:0] data, input logic [3:0] dp);
    int st, pre, idx;
    logic [3:0]  expAn;
    logic [6:0]  expSD, expSH;
    logic        expDp;
    iLoad = load;
    iData = data;
    iDp   = dp;
    if (load) begin
      mLatData = data;
      mLatDp   = dp;
    end
    if (s > 0 && s % P == 0) begin
      mActData = mLatData;
      mActDp   = mLatDp;
    end
    st  = s;
    pre = st % CD;
    idx = (st / CD) % ND;
    if (pre < BC) begin
      expAn = 4'hF; expSD = 7'h7F; expSH = 7'h7F; expDp = 1'b1;
    end else begin
      expAn = ~(4'b0001 << idx);
      expSD = expSeg(mActData, idx, 1'b0);
      expSH = expSeg(mActData, idx, 1'b1);
      expDp = ~mActDp[idx];
    end
    @(posedge iClk);
    #1;
    s++;
    iLoad = 1'b0;
    checkOutput("anDec", 16'(anDec), 16'(expAn));
    checkOutput("segDec", 16'(segDec), 16'(expSD));
    checkOutput("dpDec", 16'(dpDec), 16'(expDp));
    checkOutput("frameDec", 16'(frameDec), 16'(s % P == 0));
    checkOutput("anHex", 16'(anHex), 16'(expAn));
    checkOutput("segHex", 16'(segHex), 16'(expSH));
    checkOutput("dpHex", 16'(dpHex), 16'(expDp));
    checkOutput("frameHex", 16'(frameHex), 16'(s % P == 0));
  endtask

  function automatic logic [15:0] randData();
    int nz;
    logic [31:0] r;
    nz = $urandom_range(0, 4);
    r  = $urandom;
    return r[15:0] & 16'(32'hFFFF >> (4 * nz));
  endfunction

  task automatic randomRun(input int cycles);
    logic [31:0] r;
    for (int n = 0; n < cycles; n++) begin
      r = $urandom;
      applyStimulus(r[2:0] == 3'b000, randData(), r[11:8]);
    end
  endtask

  task automatic resetModel();
    s = 0;
    mActData = '0; mActDp = '0;
    mLatData = '0; mLatDp = '0;
  endtask

  initial begin
    bit found;
    decTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    hexTab = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    iRst_n = 1'b0; iLoad = 1'b0; iData = '0; iDp = '0;
    resetModel();

    repeat (3) @(posedge iClk);
    #1;
    checkDark("reset");
    iRst_n = 1'b1;

    // The first frame after reset shows zeros. Then a mid-frame load is issued.
    repeat (P + 5) applyStimulus(1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 16'h1234, 4'b0100);
    repeat (P + 4) applyStimulus(1'b0, 16'h0, 4'h0);

    // Two loads in one frame: the last one wins.
    applyStimulus(1'b1, 16'h5678, 4'b0001);
    applyStimulus(1'b1, 16'h9012, 4'b1000);
    repeat (P) applyStimulus(1'b0, 16'h0, 4'h0);

    // Loads that land exactly in the oFrame cycle.
    foreach (hexTab[k]) begin
      while (s % P != 0) applyStimulus(1'b0, 16'h0, 4'h0);
      applyStimulus(1'b1, (k % 2 == 0) ? 16'hABCD : 16'h0070, 4'(k));
      repeat (P - 1) applyStimulus(1'b0, 16'h0, 4'h0);
    end
    applyStimulus(1'b1, 16'h0000, 4'b0001);
    repeat (2 * P) applyStimulus(1'b0, 16'h0, 4'h0);

    randomRun(400);

    // Reset in the middle of digit 2's visible part of the slot.
    applyStimulus(1'b1, 16'h4321, 4'b1111);
    found = 1'b0;
    for (int n = 0; n < 4 * P; n++) begin
      if (s % CD == 2 && (s / CD) % ND == 2) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 16'h0, 4'h0);
    end
    checkOutput("seekDigit2", 16'(found), 16'h1);
    iRst_n = 1'b0;
    #1;
    checkDark("midReset");
    @(posedge iClk);
    #1;
    checkDark("midResetHeld");
    iRst_n = 1'b1;
    resetModel();
    repeat (P + 3) applyStimulus(1'b0, 16'h0, 4'h0);
    randomRun(300);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
